// File: rtl/risc8_prefetch_biu.sv
// risc8 bus interface unit: opcode prefetch FIFO plus data-access arbitration on a
// single-master bus. Data accesses win over prefetch; flush redirects fetching.
module risc8_prefetch_biu #(
  parameter int unsigned   AW       = 16,
  parameter int unsigned   DW       = 8,
  parameter int unsigned   DEPTH    = 4,
  parameter logic [AW-1:0] RESET_PC = '0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  // prefetch queue
  input  logic                     fetch_en,
  input  logic                     flush,
  input  logic [AW-1:0]            flush_addr,
  input  logic                     q_pop,
  output logic [DW-1:0]            q_data,
  output logic                     q_valid,
  output logic [$clog2(DEPTH):0]   q_count,
  output logic [AW-1:0]            fetch_pc,
  // data access port
  input  logic                     d_req,
  input  logic                     d_write,
  input  logic [AW-1:0]            d_addr,
  input  logic [DW-1:0]            d_wdata,
  output logic                     d_busy,
  output logic                     d_done,
  output logic [DW-1:0]            d_rdata,
  // external bus
  output logic                     cycle,
  output logic                     write,
  output logic                     ifetch,
  output logic [AW-1:0]            address,
  output logic [DW-1:0]            data_out,
  input  logic [DW-1:0]            data_in,
  input  logic                     ready
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef enum logic [1:0] {StIdle, StInst, StData} state_e;

  state_e         state_q, state_d;
  logic           cycle_q, cycle_d;
  logic           write_q, write_d;
  logic           ifetch_q, ifetch_d;
  logic [AW-1:0]  address_q, address_d;
  logic [DW-1:0]  data_out_q, data_out_d;

  logic           d_pend_q, d_pend_d;
  logic           d_busy_q, d_busy_d;
  logic           d_done_q, d_done_d;
  logic [DW-1:0]  d_rdata_q, d_rdata_d;
  logic           d_write_q;
  logic [AW-1:0]  d_addr_q;
  logic [DW-1:0]  d_wdata_q;

  logic [DW-1:0]  mem [DEPTH];
  logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]  count_q, count_d;
  logic [AW-1:0]  fetch_pc_q, fetch_pc_d;
  logic           kill_q, kill_d;

  logic           decide;
  logic           d_accept;
  logic           data_go;
  logic           inst_done;
  logic           data_done;
  logic           push;
  logic           pop;
  logic           space_ok;

  always_comb begin
    decide    = (state_q == StIdle) || ready;
    inst_done = (state_q == StInst) && ready;
    data_done = (state_q == StData) && ready;
    d_accept  = d_req && !d_busy_q;
    data_go   = d_pend_q || d_accept;
    // A killed fetch, or one finishing under a flush, never reaches the queue.
    push      = inst_done && !kill_q && !flush;
    pop       = q_pop && (count_q != '0) && !flush;
    // Same-clock pops are deliberately not credited here.
    space_ok  = (count_q + CW'(push)) < CW'(DEPTH);
  end

  // Queue bookkeeping and fetch address.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    fetch_pc_d = fetch_pc_q;
    kill_d     = kill_q;
    if (flush) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      fetch_pc_d = flush_addr;
    end else begin
      wr_ptr_d = wr_ptr_q + PW'(push);
      rd_ptr_d = rd_ptr_q + PW'(pop);
      count_d  = count_q + CW'(push) - CW'(pop);
      if (push) begin
        fetch_pc_d = fetch_pc_q + AW'(1);
      end
    end
    if (inst_done) begin
      kill_d = 1'b0;
    end else if (flush && (state_q == StInst)) begin
      kill_d = 1'b1;
    end
  end

  // Bus FSM, data-access tracking and registered bus outputs.
  always_comb begin
    state_d    = state_q;
    cycle_d    = cycle_q;
    write_d    = write_q;
    ifetch_d   = ifetch_q;
    address_d  = address_q;
    data_out_d = data_out_q;
    d_pend_d   = d_pend_q;
    d_busy_d   = d_busy_q;
    d_done_d   = data_done;
    d_rdata_d  = d_rdata_q;

    if (d_accept) begin
      d_pend_d = 1'b1;
      d_busy_d = 1'b1;
    end
    if (data_done) begin
      d_busy_d = 1'b0;
      if (!write_q) begin
        d_rdata_d = data_in;
      end
    end

    if (decide) begin
      if (data_go) begin
        state_d    = StData;
        cycle_d    = 1'b1;
        ifetch_d   = 1'b0;
        d_pend_d   = 1'b0;
        // A strobe accepted this clock has not reached the latches yet.
        write_d    = d_pend_q ? d_write_q : d_write;
        address_d  = d_pend_q ? d_addr_q  : d_addr;
        data_out_d = d_pend_q ? d_wdata_q : d_wdata;
      end else if (fetch_en && !flush && space_ok) begin
        state_d   = StInst;
        cycle_d   = 1'b1;
        ifetch_d  = 1'b1;
        write_d   = 1'b0;
        address_d = fetch_pc_d;
      end else begin
        state_d  = StIdle;
        cycle_d  = 1'b0;
        ifetch_d = 1'b0;
        write_d  = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      cycle_q    <= 1'b0;
      write_q    <= 1'b0;
      ifetch_q   <= 1'b0;
      address_q  <= '0;
      data_out_q <= '0;
      d_pend_q   <= 1'b0;
      d_busy_q   <= 1'b0;
      d_done_q   <= 1'b0;
      d_rdata_q  <= '0;
      d_write_q  <= 1'b0;
      d_addr_q   <= '0;
      d_wdata_q  <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      fetch_pc_q <= RESET_PC;
      kill_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cycle_q    <= cycle_d;
      write_q    <= write_d;
      ifetch_q   <= ifetch_d;
      address_q  <= address_d;
      data_out_q <= data_out_d;
      d_pend_q   <= d_pend_d;
      d_busy_q   <= d_busy_d;
      d_done_q   <= d_done_d;
      d_rdata_q  <= d_rdata_d;
      if (d_accept) begin
        d_write_q <= d_write;
        d_addr_q  <= d_addr;
        d_wdata_q <= d_wdata;
      end
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      fetch_pc_q <= fetch_pc_d;
      kill_q     <= kill_d;
    end
  end

  // Queue storage carries no reset; occupancy is tracked by count_q.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_q] <= data_in;
    end
  end

  assign q_data   = mem[rd_ptr_q];
  assign q_valid  = (count_q != '0);
  assign q_count  = count_q;
  assign fetch_pc = fetch_pc_q;
  assign d_busy   = d_busy_q;
  assign d_done   = d_done_q;
  assign d_rdata  = d_rdata_q;
  assign cycle    = cycle_q;
  assign write    = write_q;
  assign ifetch   = ifetch_q;
  assign address  = address_q;
  assign data_out = data_out_q;

endmodule

// File: tb/tb_risc8_prefetch_biu.sv
// Directed bench for risc8_prefetch_biu: a per-clock vector table for fill/drain,
// then hand sequences for data arbitration, flush/kill, pc wrap and async reset.
module tb_risc8_prefetch_biu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fetch_en, flush, q_pop;
  logic [15:0] flush_addr;
  logic [7:0]  q_data;
  logic        q_valid;
  logic [2:0]  q_count;
  logic [15:0] fetch_pc;
  logic        d_req, d_write;
  logic [15:0] d_addr;
  logic [7:0]  d_wdata;
  logic        d_busy, d_done;
  logic [7:0]  d_rdata;
  logic        cycle, write, ifetch;
  logic [15:0] address;
  logic [7:0]  data_out, data_in;
  logic        ready;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Memory model: each byte is its address low byte xor 0xA5.
  assign data_in = address[7:0] ^ 8'hA5;

  risc8_prefetch_biu dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .fetch_en   (fetch_en),
    .flush      (flush),
    .flush_addr (flush_addr),
    .q_pop      (q_pop),
    .q_data     (q_data),
    .q_valid    (q_valid),
    .q_count    (q_count),
    .fetch_pc   (fetch_pc),
    .d_req      (d_req),
    .d_write    (d_write),
    .d_addr     (d_addr),
    .d_wdata    (d_wdata),
    .d_busy     (d_busy),
    .d_done     (d_done),
    .d_rdata    (d_rdata),
    .cycle      (cycle),
    .write      (write),
    .ifetch     (ifetch),
    .address    (address),
    .data_out   (data_out),
    .data_in    (data_in),
    .ready      (ready)
  );

  typedef struct {
    logic        fe;
    logic        rdy;
    logic        pop;
    logic        cyc;
    logic        ifc;
    logic [15:0] addr;
    int          cnt;
    logic [15:0] fpc;
    logic        chkq;
    logic [7:0]  qd;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset(input string tag);
    check({tag, " cycle"}, 32'(cycle), 0);
    check({tag, " write"}, 32'(write), 0);
    check({tag, " ifetch"}, 32'(ifetch), 0);
    check({tag, " address"}, 32'(address), 0);
    check({tag, " data_out"}, 32'(data_out), 0);
    check({tag, " q_count"}, 32'(q_count), 0);
    check({tag, " q_valid"}, 32'(q_valid), 0);
    check({tag, " d_busy"}, 32'(d_busy), 0);
    check({tag, " d_done"}, 32'(d_done), 0);
    check({tag, " d_rdata"}, 32'(d_rdata), 0);
    check({tag, " fetch_pc"}, 32'(fetch_pc), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    //            fe rdy pop cyc ifc addr     cnt fpc      chkq qd
    vecs[0]  = '{1, 1, 0, 1, 1, 16'h0000, 0, 16'h0000, 0, 8'h00};
    vecs[1]  = '{1, 1, 0, 1, 1, 16'h0001, 1, 16'h0001, 1, 8'hA5};
    vecs[2]  = '{1, 1, 0, 1, 1, 16'h0002, 2, 16'h0002, 1, 8'hA5};
    vecs[3]  = '{1, 1, 0, 1, 1, 16'h0003, 3, 16'h0003, 1, 8'hA5};
    vecs[4]  = '{1, 1, 0, 0, 0, 16'h0000, 4, 16'h0004, 1, 8'hA5};
    vecs[5]  = '{1, 1, 0, 0, 0, 16'h0000, 4, 16'h0004, 1, 8'hA5};
    vecs[6]  = '{1, 1, 1, 0, 0, 16'h0000, 3, 16'h0004, 1, 8'hA4};
    vecs[7]  = '{1, 1, 1, 1, 1, 16'h0004, 2, 16'h0004, 1, 8'hA7};
    vecs[8]  = '{1, 1, 1, 1, 1, 16'h0005, 2, 16'h0005, 1, 8'hA6};
    vecs[9]  = '{1, 1, 0, 1, 1, 16'h0006, 3, 16'h0006, 1, 8'hA6};
    vecs[10] = '{1, 1, 0, 0, 0, 16'h0000, 4, 16'h0007, 1, 8'hA6};
    vecs[11] = '{1, 1, 1, 0, 0, 16'h0000, 3, 16'h0007, 1, 8'hA1};
    vecs[12] = '{1, 1, 0, 1, 1, 16'h0007, 3, 16'h0007, 1, 8'hA1};
    vecs[13] = '{1, 1, 0, 0, 0, 16'h0000, 4, 16'h0008, 1, 8'hA1};

    rst_n = 1'b0; fetch_en = 1'b1; flush = 1'b0; flush_addr = '0; q_pop = 1'b0;
    d_req = 1'b0; d_write = 1'b0; d_addr = '0; d_wdata = '0; ready = 1'b1;
    step();
    step();
    check_reset("rst");
    rst_n = 1'b1;

    // Fill from reset, then drain/refill one slot at a time.
    for (int i = 0; i < 14; i++) begin
      fetch_en = vecs[i].fe;
      ready    = vecs[i].rdy;
      q_pop    = vecs[i].pop;
      step();
      check($sformatf("v%0d cycle", i), 32'(cycle), 32'(vecs[i].cyc));
      check($sformatf("v%0d ifetch", i), 32'(ifetch), 32'(vecs[i].ifc));
      check($sformatf("v%0d write", i), 32'(write), 0);
      check($sformatf("v%0d q_count", i), 32'(q_count), 32'(vecs[i].cnt));
      check($sformatf("v%0d q_valid", i), 32'(q_valid), 32'(vecs[i].cnt != 0));
      check($sformatf("v%0d fetch_pc", i), 32'(fetch_pc), 32'(vecs[i].fpc));
      if (vecs[i].cyc) check($sformatf("v%0d address", i), 32'(address), 32'(vecs[i].addr));
      if (vecs[i].chkq) check($sformatf("v%0d q_data", i), 32'(q_data), 32'(vecs[i].qd));
    end
    q_pop = 1'b0;

    // Data read arriving during a stalled fetch waits for it, then runs once.
    q_pop = 1'b1;
    step();
    check("dr free slot count", 32'(q_count), 3);
    q_pop = 1'b0; ready = 1'b0;
    step();
    check("dr fetch start cycle", 32'(cycle), 1);
    check("dr fetch start addr", 32'(address), 16'h0008);
    d_req = 1'b1; d_write = 1'b0; d_addr = 16'h1234;
    step();
    check("dr busy after req", 32'(d_busy), 1);
    check("dr fetch still ifetch", 32'(ifetch), 1);
    d_write = 1'b1; d_addr = 16'h5555; d_wdata = 8'hEE;
    step();
    d_req = 1'b0;
    step();
    check("dr fetch held addr", 32'(address), 16'h0008);
    ready = 1'b1;
    step();
    check("dr data cycle", 32'(cycle), 1);
    check("dr data ifetch", 32'(ifetch), 0);
    check("dr data write", 32'(write), 0);
    check("dr data addr", 32'(address), 16'h1234);
    check("dr fetch pushed", 32'(q_count), 4);
    check("dr fetch_pc adv", 32'(fetch_pc), 16'h0009);
    check("dr done not yet", 32'(d_done), 0);
    step();
    check("dr done pulse", 32'(d_done), 1);
    check("dr busy clear", 32'(d_busy), 0);
    check("dr rdata", 32'(d_rdata), 8'h91);
    check("dr bus idle", 32'(cycle), 0);
    step();
    check("dr done single", 32'(d_done), 0);
    check("dr no second access", 32'(cycle), 0);

    // Flush together with pop on a full queue, then flush during a stalled fetch.
    flush = 1'b1; flush_addr = 16'h0005; q_pop = 1'b1;
    step();
    check("fl pop count", 32'(q_count), 0);
    check("fl pop valid", 32'(q_valid), 0);
    check("fl pop pc", 32'(fetch_pc), 16'h0005);
    check("fl no fetch", 32'(cycle), 0);
    flush = 1'b0; q_pop = 1'b0; ready = 1'b0;
    step();
    check("fl fetch5 addr", 32'(address), 16'h0005);
    flush = 1'b1; flush_addr = 16'h0200;
    step();
    check("fl inflight held", 32'(address), 16'h0005);
    check("fl inflight pc", 32'(fetch_pc), 16'h0200);
    flush = 1'b0; ready = 1'b1;
    step();
    check("fl killed count", 32'(q_count), 0);
    check("fl killed pc", 32'(fetch_pc), 16'h0200);
    check("fl redirect addr", 32'(address), 16'h0200);
    check("fl redirect ifetch", 32'(ifetch), 1);
    step();
    check("fl first byte count", 32'(q_count), 1);
    check("fl first byte data", 32'(q_data), 8'hA5);
    check("fl first byte pc", 32'(fetch_pc), 16'h0201);

    // Simultaneous push and pop at count 2.
    step();
    check("pp count2", 32'(q_count), 2);
    q_pop = 1'b1;
    step();
    check("pp count held", 32'(q_count), 2);
    check("pp head", 32'(q_data), 8'hA4);
    check("pp pc", 32'(fetch_pc), 16'h0203);

    // fetch_pc wraps at the top of the address space.
    q_pop = 1'b0; flush = 1'b1; flush_addr = 16'hFFFF;
    step();
    check("wr flush count", 32'(q_count), 0);
    check("wr flush pc", 32'(fetch_pc), 16'hFFFF);
    flush = 1'b0;
    step();
    check("wr fetch addr", 32'(address), 16'hFFFF);
    step();
    check("wr pc wrapped", 32'(fetch_pc), 16'h0000);
    check("wr byte", 32'(q_data), 8'h5A);
    check("wr next addr", 32'(address), 16'h0000);

    // Write access starting back-to-back, then reset in the middle of it.
    fetch_en = 1'b0; d_req = 1'b1; d_write = 1'b1; d_addr = 16'h00AB; d_wdata = 8'h3C;
    step();
    check("wd write", 32'(write), 1);
    check("wd ifetch", 32'(ifetch), 0);
    check("wd addr", 32'(address), 16'h00AB);
    check("wd data_out", 32'(data_out), 8'h3C);
    check("wd busy", 32'(d_busy), 1);
    check("wd count", 32'(q_count), 2);
    d_req = 1'b0; ready = 1'b0;
    step();
    check("wd held cycle", 32'(cycle), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset("arst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
